// File: rtl/fc_act_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : fc_act_loader_if
// Brief    : Activation stream in, parallel FC activation bus out.
// Revision : 1.0 - initial release
// ============================================================================
interface fc_act_loader_if #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
);
  logic [WIDTH-1:0]          s_data;
  logic                      s_valid;
  logic                      s_last;
  logic                      s_ready;
  logic [0:IN-1][WIDTH-1:0]  x;
  logic                      x_valid;
  logic                      x_ack;
  logic                      err_len;
  logic [15:0]               frames;

  modport master (
    output s_data, s_valid, s_last, x_ack,
    input  s_ready, x, x_valid, err_len, frames
  );

  modport slave (
    input  s_data, s_valid, s_last, x_ack,
    output s_ready, x, x_valid, err_len, frames
  );
endinterface
`default_nettype wire

// File: rtl/fc_act_loader.sv
`default_nettype none
// ============================================================================
// Module   : fc_act_loader
// Brief    : Gathers one frame of IN activations and holds it for the FC layer.
//            Optional macro ACT_LOADER_PINGPONG_EN adds a second bank.
// Revision : 1.0 - initial release
// ============================================================================
module fc_act_loader #(
  parameter int WIDTH = 8,
  parameter int IN    = 128
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  fc_act_loader_if.slave        bus
);

  localparam int              c_IW   = $clog2(IN);
  localparam logic [c_IW-1:0] c_LAST = c_IW'(IN - 1);

  typedef logic [0:IN-1][WIDTH-1:0] frame_t;

  logic [c_IW-1:0] r_idx;
  logic [15:0]     r_frames;
  logic            r_err;
  logic            w_acc;
  logic            w_end;
  logic            w_bad;

  assign w_acc = bus.s_valid & bus.s_ready;
  assign w_end = w_acc & ((r_idx == c_LAST) | bus.s_last);
  // A frame is well-formed only when s_last lands exactly on the final slot.
  assign w_bad = ~((r_idx == c_LAST) & bus.s_last);

  assign bus.err_len = r_err;
  assign bus.frames  = r_frames;

`ifdef ACT_LOADER_PINGPONG_EN
  frame_t     r_bank [2];
  logic [1:0] r_full;
  logic [1:0] r_berr;
  logic       r_wsel;
  logic       r_psel;
  logic       w_ack;

  assign w_ack       = bus.x_ack & r_full[r_psel];
  assign bus.s_ready = ~r_full[r_wsel];
  assign bus.x_valid = r_full[r_psel];
  assign bus.x       = r_bank[r_psel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank[0] <= '0;
      r_bank[1] <= '0;
      r_full    <= 2'b00;
      r_berr    <= 2'b00;
      r_wsel    <= 1'b0;
      r_psel    <= 1'b0;
      r_idx     <= '0;
      r_frames  <= 16'd0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_acc) begin
        r_bank[r_wsel][r_idx] <= bus.s_data;
        if (w_end) begin
          r_full[r_wsel] <= 1'b1;
          r_berr[r_wsel] <= w_bad;
          r_wsel         <= ~r_wsel;
          r_idx          <= '0;
        end else begin
          r_idx <= r_idx + c_IW'(1);
        end
      end
      // Fill and release always touch different banks, so both may happen at once.
      if (w_ack) begin
        r_bank[r_psel] <= '0;
        r_full[r_psel] <= 1'b0;
        r_psel         <= ~r_psel;
        if (r_full[~r_psel]) begin
          r_frames <= r_frames + 16'd1;
          r_err    <= r_berr[~r_psel];
        end else if (w_end) begin
          r_frames <= r_frames + 16'd1;
          r_err    <= w_bad;
        end
      end else if (w_end && (r_wsel == r_psel)) begin
        r_frames <= r_frames + 16'd1;
        r_err    <= w_bad;
      end
    end
  end
`else
  typedef enum logic [0:0] {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t r_state;
  frame_t r_buf;
  logic   r_ready;
  logic   r_xvalid;

  assign bus.s_ready = r_ready;
  assign bus.x_valid = r_xvalid;
  assign bus.x       = r_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= FILL;
      r_buf    <= '0;
      r_ready  <= 1'b1;
      r_xvalid <= 1'b0;
      r_idx    <= '0;
      r_frames <= 16'd0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_acc) begin
            r_buf[r_idx] <= bus.s_data;
            if (w_end) begin
              r_state  <= HOLD;
              r_ready  <= 1'b0;
              r_xvalid <= 1'b1;
              r_err    <= w_bad;
              r_frames <= r_frames + 16'd1;
            end else begin
              r_idx <= r_idx + c_IW'(1);
            end
          end
        end
        HOLD: begin
          if (bus.x_ack) begin
            r_state  <= FILL;
            r_buf    <= '0;
            r_ready  <= 1'b1;
            r_xvalid <= 1'b0;
            r_idx    <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end
`endif

endmodule
`default_nettype wire
